// File: rtl/despread_sync_pkg.sv
// rtl/despread_sync_pkg.sv - shared state encoding and default widths for the despreader sync sequencer
package despread_sync_pkg;

    localparam int CORR_W_DEF       = 7;
    localparam int LOCK_W_DEF       = 16;
    localparam int SLIP_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEARCH   = 2'd1,
        ST_SLIPWAIT = 2'd2,
        ST_LOCKED   = 2'd3
    } sync_state_e;

endpackage

// File: rtl/despread_slip_wd.sv
// rtl/despread_slip_wd.sv - slip-ack watchdog; counts SLIPWAIT cycles (built only with DESPREAD_SLIP_WD_EN)
`ifdef DESPREAD_SLIP_WD_EN
module despread_slip_wd #(
    parameter int SLIP_TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_active,
    output logic o_expire
);

    localparam int CNT_W = $clog2(SLIP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLIP_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counter restarts whenever the sequencer leaves SLIPWAIT, so every slip gets a full window.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_active) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_active && (r_cnt == LAST);

endmodule
`endif

// File: rtl/despread_sync_ctrl.sv
// rtl/despread_sync_ctrl.sv - code-phase acquisition/tracking sequencer for one despreader channel
// Optional slip-ack watchdog enabled by defining DESPREAD_SLIP_WD_EN.
module despread_sync_ctrl
    import despread_sync_pkg::*;
#(
    parameter int CORR_W = CORR_W_DEF,
    parameter int LOCK_W = LOCK_W_DEF
`ifdef DESPREAD_SLIP_WD_EN
    ,
    parameter int SLIP_TIMEOUT = SLIP_TIMEOUT_DEF
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_corrValid,
    input  logic [CORR_W-1:0] i_corrMag,
    input  logic [CORR_W-1:0] i_acqSyncThreshold,
    input  logic [CORR_W-1:0] i_trkSyncThreshold,
    input  logic [LOCK_W-1:0] i_lockCount,
    input  logic              i_manualSlip,
    input  logic              i_slipped,
    output logic              o_slip,
    output logic              o_locked,
    output logic [1:0]        o_syncState,
    output logic [LOCK_W-1:0] o_slipCount,
    output logic              o_slipTimeout
);

    sync_state_e       r_state;
    sync_state_e       w_state_nxt;
    sync_state_e       r_ret_state;
    sync_state_e       w_ret_nxt;
    logic [LOCK_W-1:0] r_miss;
    logic [LOCK_W-1:0] w_miss_nxt;
    logic [LOCK_W-1:0] w_miss_sat;
    logic [LOCK_W:0]   w_miss_inc;
    logic [LOCK_W:0]   w_lock_lim;
    logic [LOCK_W-1:0] r_slip_count;
    logic [LOCK_W-1:0] w_slip_count_nxt;
    logic              r_manual_d;
    logic              w_manual_edge;
    logic              r_slip;
    logic              r_locked;
    logic              r_timeout;
    logic              w_slip_nxt;
    logic              w_locked_nxt;
    logic              w_timeout_nxt;
    logic              w_wd_expire;

`ifdef DESPREAD_SLIP_WD_EN
    despread_slip_wd #(
        .SLIP_TIMEOUT(SLIP_TIMEOUT)
    ) u_slip_wd (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_active (r_state == ST_SLIPWAIT),
        .o_expire (w_wd_expire)
    );
`else
    assign w_wd_expire = 1'b0;
`endif

    assign w_manual_edge = i_manualSlip && !r_manual_d;

    // Extra bit keeps the drop compare correct once the miss counter has saturated.
    assign w_miss_inc = {1'b0, r_miss} + (LOCK_W + 1)'(1);
    assign w_miss_sat = (&r_miss) ? r_miss : r_miss + LOCK_W'(1);
    assign w_lock_lim = (i_lockCount == '0) ? (LOCK_W + 1)'(1) : {1'b0, i_lockCount};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ret_state  <= ST_IDLE;
            r_miss       <= '0;
            r_slip_count <= '0;
            r_manual_d   <= 1'b0;
            r_slip       <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ret_state  <= w_ret_nxt;
            r_miss       <= w_miss_nxt;
            r_slip_count <= w_slip_count_nxt;
            r_manual_d   <= i_manualSlip;
            r_slip       <= w_slip_nxt;
            r_locked     <= w_locked_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ret_nxt        = r_ret_state;
        w_miss_nxt       = r_miss;
        w_slip_count_nxt = r_slip_count;
        w_timeout_nxt    = r_timeout;
        if (!i_enable) begin
            w_state_nxt   = ST_IDLE;
            w_miss_nxt    = '0;
            w_timeout_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_SEARCH;
                ST_SEARCH: begin
                    // A manual slip takes priority and the coincident epoch is dropped.
                    if (w_manual_edge) begin
                        w_state_nxt = ST_SLIPWAIT;
                        w_ret_nxt   = ST_SEARCH;
                    end else if (i_corrValid) begin
                        if (i_corrMag >= i_acqSyncThreshold) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = '0;
                        end else begin
                            w_state_nxt = ST_SLIPWAIT;
                            w_ret_nxt   = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_manual_edge) begin
                        w_state_nxt = ST_SLIPWAIT;
                        w_ret_nxt   = ST_LOCKED;
                    end else if (i_corrValid) begin
                        if (i_corrMag >= i_trkSyncThreshold) begin
                            w_miss_nxt = '0;
                        end else begin
                            w_miss_nxt = w_miss_sat;
                            if (w_miss_inc >= w_lock_lim) begin
                                w_state_nxt = ST_SLIPWAIT;
                                w_ret_nxt   = ST_SEARCH;
                            end
                        end
                    end
                end
                ST_SLIPWAIT: begin
                    if (i_slipped) begin
                        w_state_nxt      = r_ret_state;
                        w_slip_count_nxt = r_slip_count + LOCK_W'(1);
                    end else if (w_wd_expire) begin
                        w_state_nxt   = ST_SEARCH;
                        w_timeout_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_slip_nxt   = 1'b0;
        w_locked_nxt = 1'b0;
        w_slip_nxt   = (w_state_nxt == ST_SLIPWAIT);
        w_locked_nxt = (w_state_nxt == ST_LOCKED);
    end

    assign o_slip        = r_slip;
    assign o_locked      = r_locked;
    assign o_syncState   = r_state;
    assign o_slipCount   = r_slip_count;
    assign o_slipTimeout = r_timeout;

endmodule

// File: tb/tb_despread_sync_ctrl.sv
// tb/tb_despread_sync_ctrl.sv - self-checking bench for despread_sync_ctrl with a behavioural reference model
module tb_despread_sync_ctrl;

    localparam int TO = 64;
    localparam int S_IDLE = 0, S_SEARCH = 1, S_WAIT = 2, S_LOCK = 3;

    logic        clk = 1'b0;
    logic        reset, enable, corrValid, manualSlip, slipped;
    logic [6:0]  corrMag, acq, trk;
    logic [15:0] lockCount;
    logic        o_slip, o_locked, o_slipTimeout;
    logic [1:0]  o_syncState;
    logic [15:0] o_slipCount;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    int m_state = 0, m_ret = 0, m_miss = 0, m_cnt = 0, m_wait = 0;
    bit m_prev = 1'b0, m_to = 1'b0;

    despread_sync_ctrl dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_enable           (enable),
        .i_corrValid        (corrValid),
        .i_corrMag          (corrMag),
        .i_acqSyncThreshold (acq),
        .i_trkSyncThreshold (trk),
        .i_lockCount        (lockCount),
        .i_manualSlip       (manualSlip),
        .i_slipped          (slipped),
        .o_slip             (o_slip),
        .o_locked           (o_locked),
        .o_syncState        (o_syncState),
        .o_slipCount        (o_slipCount),
        .o_slipTimeout      (o_slipTimeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: spec rules applied once per clock to the sampled inputs.
    always @(posedge clk) begin
        int s, r, mi, c, w, lim;
        bit to, edge_seen;
        s = m_state; r = m_ret; mi = m_miss; c = m_cnt; w = m_wait; to = m_to;
        edge_seen = manualSlip && !m_prev;
        lim = (lockCount == 0) ? 1 : int'(lockCount);
        if (reset) begin
            s = S_IDLE; r = S_IDLE; mi = 0; c = 0; w = 0; to = 1'b0;
        end else if (!enable) begin
            s = S_IDLE; mi = 0; w = 0; to = 1'b0;
        end else if (s == S_IDLE) begin
            s = S_SEARCH;
        end else if (s == S_SEARCH) begin
            if (edge_seen) begin
                s = S_WAIT; r = S_SEARCH; w = 0;
            end else if (corrValid && corrMag >= acq) begin
                s = S_LOCK; mi = 0;
            end else if (corrValid) begin
                s = S_WAIT; r = S_SEARCH; w = 0;
            end
        end else if (s == S_LOCK) begin
            if (edge_seen) begin
                s = S_WAIT; r = S_LOCK; w = 0;
            end else if (corrValid && corrMag >= trk) begin
                mi = 0;
            end else if (corrValid) begin
                if (mi + 1 >= lim) begin
                    s = S_WAIT; r = S_SEARCH; w = 0;
                end
                mi = (mi + 1 > 65535) ? 65535 : mi + 1;
            end
        end else begin
            if (slipped) begin
                s = r; c = (c + 1) % 65536; w = 0;
            end else begin
                w = w + 1;
`ifdef DESPREAD_SLIP_WD_EN
                if (w == TO) begin
                    s = S_SEARCH; to = 1'b1; w = 0;
                end
`endif
            end
        end
        m_state <= s; m_ret <= r; m_miss <= mi; m_cnt <= c; m_wait <= w; m_to <= to;
        m_prev  <= reset ? 1'b0 : manualSlip;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_syncState", 32'(o_syncState), 32'(m_state));
            chk("model_slip", 32'(o_slip), 32'(m_state == S_WAIT));
            chk("model_locked", 32'(o_locked), 32'(m_state == S_LOCK));
            chk("model_slipCount", 32'(o_slipCount), 32'(m_cnt));
            chk("model_slipTimeout", 32'(o_slipTimeout), 32'(m_to));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int m);
        corrValid = 1'b1;
        corrMag = 7'(m);
        cyc();
        corrValid = 1'b0;
    endtask

    task automatic ack();
        slipped = 1'b1;
        cyc();
        slipped = 1'b0;
    endtask

    initial begin
        int mags[6];
        mags = '{5, 5, 25, 5, 5, 5};
        reset = 1'b1; enable = 1'b0; corrValid = 1'b0; manualSlip = 1'b0; slipped = 1'b0;
        corrMag = '0; acq = 7'd40; trk = 7'd20; lockCount = 16'd3;
        cyc();
        cyc();
        cmp_on = 1'b1;
        chk("rst_state", 32'(o_syncState), 0);
        chk("rst_slip", 32'(o_slip), 0);
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_count", 32'(o_slipCount), 0);
        chk("rst_timeout", 32'(o_slipTimeout), 0);
        reset = 1'b0;

        enable = 1'b1;
        cyc();
        chk("idle_to_search", 32'(o_syncState), 1);
        pulse(45);
        chk("acq_state", 32'(o_syncState), 3);
        chk("acq_locked", 32'(o_locked), 1);
        chk("acq_no_slip", 32'(o_slip), 0);

        enable = 1'b0; cyc(); enable = 1'b1; cyc();
        pulse(10);
        chk("acq_miss_slip", 32'(o_slip), 1);
        repeat (4) cyc();
        chk("slip_held", 32'(o_slip), 1);
        ack();
        chk("ack_slip_low", 32'(o_slip), 0);
        chk("ack_count", 32'(o_slipCount), 1);
        chk("ack_search", 32'(o_syncState), 1);

        pulse(45);
        chk("relock", 32'(o_syncState), 3);
        for (int i = 0; i < 6; i++) begin
            pulse(mags[i]);
            if (i < 5) chk("trk_hold", 32'(o_syncState), 3);
            else       chk("trk_drop", 32'(o_syncState), 2);
            cyc();
        end
        ack();
        chk("drop_ack_search", 32'(o_syncState), 1);
        chk("drop_ack_count", 32'(o_slipCount), 2);

        pulse(45);
        pulse(5);
        chk("one_miss_locked", 32'(o_syncState), 3);
        manualSlip = 1'b1;
        pulse(0);
        chk("manual_wins", 32'(o_syncState), 2);
        cyc();
        ack();
        chk("manual_ret_locked", 32'(o_syncState), 3);
        chk("manual_count", 32'(o_slipCount), 3);
        pulse(0);
        chk("miss_kept_hold", 32'(o_syncState), 3);
        pulse(0);
        chk("miss_kept_drop", 32'(o_syncState), 2);
        manualSlip = 1'b0;
        ack();
        chk("count4", 32'(o_slipCount), 4);

        pulse(0);
        cyc();
        enable = 1'b0;
        cyc();
        chk("dis_idle", 32'(o_syncState), 0);
        chk("dis_slip", 32'(o_slip), 0);
        chk("dis_count", 32'(o_slipCount), 4);
        ack();
        chk("dis_late_ack", 32'(o_slipCount), 4);
        enable = 1'b1;
        cyc();
        cyc();
        ack();
        chk("stale_ack_state", 32'(o_syncState), 1);
        chk("stale_ack_count", 32'(o_slipCount), 4);

        lockCount = 16'd0;
        pulse(45);
        pulse(0);
        chk("lc0_drop", 32'(o_syncState), 2);
        ack();
        lockCount = 16'd3;
        chk("lc0_count", 32'(o_slipCount), 5);

        enable = 1'b0; cyc();
        manualSlip = 1'b1; cyc();
        enable = 1'b1; cyc(); cyc();
        chk("idle_edge_ignored", 32'(o_syncState), 1);
        manualSlip = 1'b0;

        pulse(0);
`ifdef DESPREAD_SLIP_WD_EN
        repeat (TO - 1) cyc();
        chk("wd_last_wait", 32'(o_slip), 1);
        cyc();
        chk("wd_state", 32'(o_syncState), 1);
        chk("wd_slip", 32'(o_slip), 0);
        chk("wd_flag", 32'(o_slipTimeout), 1);
        chk("wd_count", 32'(o_slipCount), 5);
        enable = 1'b0; cyc();
        chk("wd_flag_clr", 32'(o_slipTimeout), 0);
        enable = 1'b1; cyc();
`else
        repeat (199) cyc();
        chk("no_wd_slip", 32'(o_slip), 1);
        chk("no_wd_timeout", 32'(o_slipTimeout), 0);
        ack();
        chk("no_wd_count", 32'(o_slipCount), 6);
`endif

        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) begin
                acq = 7'($urandom_range(0, 127));
                trk = 7'($urandom_range(0, 127));
                lockCount = 16'($urandom_range(0, 4));
            end
            reset = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 99) != 0);
            corrValid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: corrMag = acq;
                1: corrMag = trk;
                2: corrMag = (trk == 0) ? 7'd0 : trk - 7'd1;
                default: corrMag = 7'($urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 15) == 0) manualSlip = ~manualSlip;
            slipped = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
